biquad_coeff_ctrl: RTL and testbench
====================================

BIQUAD_COEFF_CTRL -- requirements
Module: biquad_coeff_ctrl

Interface
REQ-001 Parameters: COEFF_WIDTH, default 16, coefficient width; COEFF_FRAC, default 14, fractional bits of coefficients; TIMEOUT, default 1024, maximum cycles to wait for a sample boundary.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wr_valid  in  1  shadow write request.
REQ-005 wr_ready  out  1  shadow write accepted when wr_valid and wr_ready are both high.
REQ-006 wr_addr  in  4  coefficient index: 0..4 = b0,b1,b2,a1,a2 of section 1; 5..9 = the same for section 2.
REQ-007 wr_data  in  COEFF_WIDTH  signed coefficient value.
REQ-008 commit_req  in  1  request to transfer the shadow bank to the active bank.
REQ-009 sample_tick  in  1  one-cycle pulse marking the filter sample boundary.
REQ-010 coeff_active  out  10*COEFF_WIDTH  active coefficients; index k occupies bits [k*COEFF_WIDTH +: COEFF_WIDTH].
REQ-011 commit_ack  out  1  one-cycle pulse when the new coefficients become active.
REQ-012 filt_clr  out  1  one-cycle pulse, coincident with commit_ack, that clears the biquad delay state.
REQ-013 busy  out  1  high in ARMED and ACK.
REQ-014 err_addr  out  1  sticky flag: a write to index 10..15 was accepted.
REQ-015 err_timeout  out  1  sticky flag: a commit was aborted because no sample_tick arrived.

Function
REQ-016 Storage: shadow bank and active bank, each holding 10 x COEFF_WIDTH bits.
REQ-017 FSM states: IDLE, ARMED, ACK.
REQ-018 IDLE:
- wr_ready=1.
- Accepted write with wr_addr<=9 updates that shadow entry on the next edge.
- wr_addr>=10: no storage change; err_addr set.
REQ-019 IDLE with commit_req=1: go to ARMED; load the timeout counter with 0.
REQ-020 Simultaneous write and commit_req in IDLE: the write lands in shadow and is included in the commit.
REQ-021 ARMED and ACK: wr_ready=0; commit_req is ignored.
REQ-022 ARMED, sample_tick=1: on the next edge, active bank <= shadow bank and state -> ACK.
REQ-023 A sample_tick in the same cycle as the IDLE->ARMED commit_req is not counted; the first qualifying tick is the one seen while in ARMED.
REQ-024 ARMED, no tick: the counter increments each cycle. When the counter equals TIMEOUT-1 with no tick, state -> IDLE, err_timeout set, active bank unchanged, shadow retained.
REQ-025 Tick and timeout in the same cycle: the tick wins and the commit proceeds.
REQ-026 ACK lasts exactly one cycle: commit_ack=1, filt_clr=1, then state -> IDLE.
REQ-027 Latency: tick sampled at edge N in ARMED; coeff_active updated and commit_ack high from edge N+1 for exactly one cycle.
REQ-028 Error-flag clearing:
- err_addr and err_timeout clear on entry to ACK or on rst.
- Set has priority over clear in the same cycle.
REQ-029 coeff_active changes only on the ARMED->ACK transition or on reset; all outputs are registered.

Reset
REQ-030 rst=1 at an edge forces, regardless of state:
- state=IDLE, counter=0.
- commit_ack=0, filt_clr=0, busy=0, err_addr=0, err_timeout=0, wr_ready=1 after release.
REQ-031 Reset value of both banks: index 0 = 1<<COEFF_FRAC (unity passthrough for section 1); all other indices = 0.
REQ-032 rst asserted in ARMED or ACK aborts any pending commit; no commit_ack is produced.

Verification
REQ-033 After rst: coeff_active index0=0x4000, others 0; write addr5=0x1234, commit, tick 3 cycles later -> commit_ack+filt_clr one cycle after tick; index5=0x1234; index0 still 0x4000.
REQ-034 Write addr2=0x0100 in the same cycle as commit_req, tick after 2 cycles -> index2=0x0100 active; wr_ready=0 from the cycle after commit_req through ACK.
REQ-035 Write addr12 -> err_addr=1, banks unchanged; the following successful commit clears err_addr.
REQ-036 TIMEOUT=8, commit with no tick -> ARMED for 8 cycles, then IDLE with err_timeout=1, coeff_active unchanged, no commit_ack.
REQ-037 sample_tick coincident with commit_req -> no swap; next tick 5 cycles later -> swap; a second commit_req during ARMED produces no extra ack.
REQ-038 rst asserted mid-ARMED, then tick -> no commit_ack; coeff_active at reset defaults.

Source files
------------

// File: rtl/biquad_coeff_ctrl.sv
// Double-buffered coefficient store for a two-section biquad. Writes land in a
// shadow bank; a commit copies shadow to active on the next sample boundary,
// pulsing commit_ack/filt_clr, or gives up after TIMEOUT cycles.
module biquad_coeff_ctrl #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned COEFF_FRAC  = 14,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [3:0]                  wr_addr_i,
  input  logic [COEFF_WIDTH-1:0]      wr_data_i,
  input  logic                        commit_req_i,
  input  logic                        sample_tick_i,
  output logic [10*COEFF_WIDTH-1:0]   coeff_active_o,
  output logic                        commit_ack_o,
  output logic                        filt_clr_o,
  output logic                        busy_o,
  output logic                        err_addr_o,
  output logic                        err_timeout_o
);

  localparam int unsigned NumCoeff = 10;
  localparam int unsigned CntW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [COEFF_WIDTH-1:0] Unity = COEFF_WIDTH'(1) << COEFF_FRAC;

  typedef logic [NumCoeff-1:0][COEFF_WIDTH-1:0] bank_t;

  // Section 1 b0 = 1.0, everything else zero: a clean passthrough after reset.
  localparam bank_t BankRst = {{((NumCoeff - 1) * COEFF_WIDTH){1'b0}}, Unity};

  typedef enum logic [1:0] {StIdle, StArmed, StAck} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  bank_t           shadow_q, shadow_d;
  bank_t           active_q, active_d;
  logic            wr_ready_q, wr_ready_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            err_addr_q, err_addr_d;
  logic            err_to_q, err_to_d;

  logic wr_fire;
  logic addr_bad;
  logic err_clr;
  logic to_set;

  assign wr_fire  = wr_valid_i & wr_ready_q;
  assign addr_bad = (wr_addr_i > 4'd9);

  // Next-state for the commit FSM, the two banks and the sticky error flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    wr_ready_d = wr_ready_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_clr    = 1'b0;
    to_set     = 1'b0;

    // wr_ready_q is only high in StIdle, so writes can never race the copy.
    if (wr_fire && !addr_bad) begin
      for (int unsigned k = 0; k < NumCoeff; k++) begin
        if (wr_addr_i == 4'(k)) begin
          shadow_d[k] = wr_data_i;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (commit_req_i) begin
          state_d    = StArmed;
          cnt_d      = '0;
          wr_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StArmed: begin
        // A tick on the last counted cycle still commits.
        if (sample_tick_i) begin
          active_d = shadow_q;
          state_d  = StAck;
          ack_d    = 1'b1;
          err_clr  = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d    = StIdle;
          cnt_d      = '0;
          to_set     = 1'b1;
          wr_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        state_d    = StIdle;
        cnt_d      = '0;
        wr_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      default: begin
        state_d    = StIdle;
        cnt_d      = '0;
        wr_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase

    // Set wins over clear.
    err_addr_d = (wr_fire && addr_bad) ? 1'b1 : (err_clr ? 1'b0 : err_addr_q);
    err_to_d   = to_set ? 1'b1 : (err_clr ? 1'b0 : err_to_q);
  end

  // State, banks and all outputs registered; synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shadow_q   <= BankRst;
      active_q   <= BankRst;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_addr_q <= err_addr_d;
      err_to_q   <= err_to_d;
    end
  end

  assign coeff_active_o = active_q;
  assign wr_ready_o     = wr_ready_q;
  assign busy_o         = busy_q;
  assign commit_ack_o   = ack_q;
  assign filt_clr_o     = ack_q;
  assign err_addr_o     = err_addr_q;
  assign err_timeout_o  = err_to_q;

endmodule

// File: tb/tb_biquad_coeff_ctrl.sv
// Bench for biquad_coeff_ctrl: table of write/commit vectors plus hand-written
// corner sequences; commits push expected banks/ack cycles onto a scoreboard
// that a negedge monitor pops when commit_ack appears.
module tb_biquad_coeff_ctrl;

  localparam int W  = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [3:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          commit_req = 1'b0;
  logic          sample_tick = 1'b0;
  logic [10*W-1:0] coeff_active;
  logic          commit_ack;
  logic          filt_clr;
  logic          busy;
  logic          err_addr;
  logic          err_timeout;

  biquad_coeff_ctrl #(
    .COEFF_WIDTH(W),
    .COEFF_FRAC (14),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .commit_req_i  (commit_req),
    .sample_tick_i (sample_tick),
    .coeff_active_o(coeff_active),
    .commit_ack_o  (commit_ack),
    .filt_clr_o    (filt_clr),
    .busy_o        (busy),
    .err_addr_o    (err_addr),
    .err_timeout_o (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_shadow [10];
  logic [W-1:0] m_active [10];
  logic         m_err_addr;
  logic         m_err_to;

  typedef struct {
    logic [159:0] act;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0]   addr;
    logic [W-1:0] data;
    bit           wr_with_commit;
    int           d;
  } vec_t;
  vec_t vecs [5];

  task automatic checkw(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack_bank(input logic [W-1:0] m [10]);
    logic [159:0] v;
    v = '0;
    for (int k = 0; k < 10; k++) v[k*W +: W] = m[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 10; k++) begin
      m_shadow[k] = (k == 0) ? 16'h4000 : 16'h0000;
      m_active[k] = (k == 0) ? 16'h4000 : 16'h0000;
    end
    m_err_addr = 1'b0;
    m_err_to   = 1'b0;
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every ack must match a pending commit, on the right cycle.
  always @(negedge clk) begin
    if (commit_ack || filt_clr) begin
      check1("filt_clr_with_ack", filt_clr, commit_ack);
      if (sb_q.size() == 0) begin
        check1("unexpected_ack", commit_ack, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        checkw("ack_coeffs", coeff_active, mon_e.act);
        checkw("ack_latency", 160'(cyc), 160'(mon_e.cyc));
      end
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [W-1:0] dat);
    check1("idle_wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = dat;
    if (a <= 4'd9) m_shadow[a] = dat;
    else m_err_addr = 1'b1;
    tick_edge();
    wr_valid = 1'b0;
    check1("wr_err_addr", err_addr, m_err_addr);
    checkw("wr_active_hold", coeff_active, pack_bank(m_active));
  endtask

  // Commit whose qualifying tick is sampled d edges after the commit edge.
  task automatic do_commit(input int d, input bit tick_at_commit, input bit recommit,
                           input bit wr_en, input logic [3:0] a, input logic [W-1:0] dat);
    exp_t e;
    commit_req  = 1'b1;
    sample_tick = tick_at_commit;
    if (wr_en) begin
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = dat;
      if (a <= 4'd9) m_shadow[a] = dat;
      else m_err_addr = 1'b1;
    end
    e.act = pack_bank(m_shadow);
    e.cyc = cyc + 1 + d;
    sb_q.push_back(e);
    tick_edge();
    commit_req  = 1'b0;
    sample_tick = 1'b0;
    wr_valid    = 1'b0;
    check1("armed_busy", busy, 1'b1);
    check1("armed_wr_ready", wr_ready, 1'b0);
    checkw("armed_hold", coeff_active, pack_bank(m_active));
    for (int i = 1; i < d; i++) begin
      commit_req = recommit && (i == 2);
      tick_edge();
      commit_req = 1'b0;
      check1("armed_busy", busy, 1'b1);
      check1("armed_wr_ready", wr_ready, 1'b0);
    end
    sample_tick = 1'b1;
    tick_edge();
    sample_tick = 1'b0;
    m_active   = m_shadow;
    m_err_addr = 1'b0;
    m_err_to   = 1'b0;
    check1("ack_pulse", commit_ack, 1'b1);
    check1("ack_wr_ready", wr_ready, 1'b0);
    check1("ack_busy", busy, 1'b1);
    check1("ack_err_addr", err_addr, m_err_addr);
    check1("ack_err_timeout", err_timeout, m_err_to);
    tick_edge();
    check1("post_ack_drop", commit_ack, 1'b0);
    check1("post_ack_busy", busy, 1'b0);
    check1("post_ack_wr_ready", wr_ready, 1'b1);
    checkw("post_ack_active", coeff_active, pack_bank(m_active));
  endtask

  initial begin
    vecs[0] = '{addr: 4'd5, data: 16'h1234, wr_with_commit: 1'b0, d: 3};
    vecs[1] = '{addr: 4'd2, data: 16'h0100, wr_with_commit: 1'b1, d: 2};
    vecs[2] = '{addr: 4'd9, data: 16'h8001, wr_with_commit: 1'b0, d: 1};
    vecs[3] = '{addr: 4'd0, data: 16'h7fff, wr_with_commit: 1'b1, d: TO};
    vecs[4] = '{addr: 4'd4, data: 16'hffff, wr_with_commit: 1'b0, d: 5};

    // Reset state.
    model_reset();
    rst = 1'b1;
    repeat (2) tick_edge();
    rst = 1'b0;
    tick_edge();
    checkw("rst_active", coeff_active, pack_bank(m_active));
    check1("rst_ack", commit_ack, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_wr_ready", wr_ready, 1'b1);
    check1("rst_err_addr", err_addr, 1'b0);
    check1("rst_err_timeout", err_timeout, 1'b0);

    // Table-driven write + commit vectors.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr_with_commit) begin
        do_commit(vecs[v].d, 1'b0, 1'b0, 1'b1, vecs[v].addr, vecs[v].data);
      end else begin
        do_write(vecs[v].addr, vecs[v].data);
        do_commit(vecs[v].d, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
      end
    end

    // Out-of-range address: flag set, banks untouched, cleared by next commit.
    do_write(4'd12, 16'hdead);
    check1("bad_addr_flag", err_addr, 1'b1);
    do_commit(2, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);

    // Timeout: 8 cycles armed, then idle with err_timeout and no swap.
    do_write(4'd1, 16'h5555);
    commit_req = 1'b1;
    tick_edge();
    commit_req = 1'b0;
    check1("to_armed", busy, 1'b1);
    for (int i = 1; i < TO; i++) begin
      tick_edge();
      check1("to_armed", busy, 1'b1);
    end
    tick_edge();
    m_err_to = 1'b1;
    check1("to_idle_busy", busy, 1'b0);
    check1("to_flag", err_timeout, m_err_to);
    check1("to_wr_ready", wr_ready, 1'b1);
    checkw("to_active_hold", coeff_active, pack_bank(m_active));
    // Shadow kept: a later commit delivers the 0x5555 write.
    do_commit(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);

    // Tick coincident with commit_req is ignored; re-request while armed is ignored.
    do_write(4'd7, 16'h0a0a);
    do_commit(5, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000);
    repeat (3) begin
      tick_edge();
      check1("no_extra_ack", commit_ack, 1'b0);
    end

    // Reset mid-ARMED aborts the commit; both banks return to defaults.
    do_write(4'd3, 16'h0abc);
    commit_req = 1'b1;
    tick_edge();
    commit_req = 1'b0;
    repeat (2) tick_edge();
    rst = 1'b1;
    tick_edge();
    rst = 1'b0;
    model_reset();
    sample_tick = 1'b1;
    tick_edge();
    sample_tick = 1'b0;
    check1("rst_abort_ack", commit_ack, 1'b0);
    check1("rst_abort_busy", busy, 1'b0);
    checkw("rst_abort_active", coeff_active, pack_bank(m_active));
    repeat (3) begin
      tick_edge();
      check1("rst_abort_no_ack", commit_ack, 1'b0);
    end
    do_commit(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);

    repeat (2) tick_edge();
    checkw("scoreboard_drained", 160'(sb_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
